// File: rtl/t_ff_pkg.sv
// Shared defaults and the toggle rule
// for the t_ff toggle flip-flop bank.
package t_ff_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned MAX_WIDTH = 64;

  function automatic logic tgl(
    input logic q,
    input logic t
  );
    return q ^ t;
  endfunction

endpackage

// File: rtl/t_ff_bit.sv
// One toggle flop with asynchronous
// active-low reset to a per-bit value.
module t_ff_bit
  import t_ff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= tgl(r_q, t);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/t_ff.sv
// Bank of WIDTH independent toggle flops
// with a combinational complement output.
module t_ff
  import t_ff_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_bit #(
      .RST_VAL(RST_VAL[i])
    ) u_bit (
      .clk(clk),
      .rst(rst),
      .t  (t[i]),
      .q  (w_q[i])
    );
  end

  // qbar is derived, never stored
  assign q    = w_q;
  assign qbar = ~w_q;

endmodule

// File: tb/tb_t_ff.sv
// Directed and random checks of t_ff in
// 1-bit default and 4-bit preset forms.
module tb_t_ff;

  logic       clk;
  logic       rst;
  logic       t1;
  logic       q1;
  logic       qb1;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qb4;

  int n_cmp;
  int n_bad;

  logic       m1;
  logic       nb1;
  logic [3:0] m4;
  logic [3:0] nb4;

  t_ff u_dut1 (
    .clk (clk),
    .rst (rst),
    .t   (t1),
    .q   (q1),
    .qbar(qb1)
  );

  t_ff #(
    .WIDTH  (4),
    .RST_VAL(4'b1010)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .t   (t4),
    .q   (q4),
    .qbar(qb4)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    nb1 = ~m1;
    nb4 = ~m4;
    chk({tag, "_q1"}, q1, m1);
    chk({tag, "_qb1"}, qb1, nb1);
    chk({tag, "_q4"}, q4, m4);
    chk({tag, "_qb4"}, qb4, nb4);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    t1    = 1'b1;
    t4    = 4'b0000;

    // 1: async reset, no clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_q1", q1, 1'b0);
    chk("rst_qb1", qb1, 1'b1);
    chk("rst_q4", q4, 4'b1010);
    chk("rst_qb4", qb4, 4'b0101);
    #2 rst = 1'b1;
    #1;
    chk("rel_q1", q1, 1'b0);
    chk("rel_qb1", qb1, 1'b1);

    // 2: hold
    t1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_q1", q1, 1'b0);
      chk("hold_qb1", qb1, 1'b1);
    end
    chk("hold_q4", q4, 4'b1010);

    // 3: toggle, change only at posedge
    t1 = 1'b1;
    m1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk("pre_edge_q1", q1, m1);
      #1 clk = 1'b1;
      #5 clk = 1'b0;
      m1  = ~m1;
      nb1 = ~m1;
      chk("tgl_q1", q1, m1);
      chk("tgl_qb1", qb1, nb1);
    end
    chk("tgl_end_q1", q1, 1'b0);

    // 4: mid-cycle reset with t held
    cyc();
    chk("pre_mid_q1", q1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_q1", q1, 1'b0);
    chk("mid_qb1", qb1, 1'b1);
    #2;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_hold_q1", q1, 1'b0);
    end
    #2 rst = 1'b1;
    #3;
    cyc();
    chk("first_tgl_q1", q1, 1'b1);

    // 5: mixed bits with preset 1010
    chk("mix_rst_q4", q4, 4'b1010);
    chk("mix_rst_qb4", qb4, 4'b0101);
    t4 = 4'b0011;
    cyc();
    chk("mix_tgl_q4", q4, 4'b1001);
    chk("mix_tgl_qb4", qb4, 4'b0110);
    t4 = 4'b0000;
    cyc();
    chk("mix_hold_q4", q4, 4'b1001);

    // 6: random stream with reset pulses
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    m1 = 1'b0;
    m4 = 4'b1010;
    chk_model("rnd_init");
    for (int i = 0; i < 200; i++) begin
      t1 = 1'($urandom_range(0, 1));
      t4 = 4'($urandom_range(0, 15));
      cyc();
      m1 = m1 ^ t1;
      m4 = m4 ^ t4;
      chk_model("rnd");
      if ($urandom_range(0, 15) == 0) begin
        #1 rst = 1'b0;
        #1;
        m1 = 1'b0;
        m4 = 4'b1010;
        chk_model("rnd_rst");
        #1 rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
